// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: strobes the matrix columns, debounces every
// key on its own and emits press/release events over valid/ready.
module key_matrix_scanner #(
  parameter  int ROWS           = 8,
  parameter  int COLS           = 8,
  parameter  int SETTLE_CYCLES  = 16,
  parameter  int DEBOUNCE_SCANS = 4,
  localparam int KB             = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [COLS-1:0] col_n,
  input  logic [ROWS-1:0] row_n,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [KB-1:0]   evt_key,
  output logic            evt_pressed,
  output logic            scan_done
);

  localparam int NK  = ROWS * COLS;
  localparam int CBW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RBW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SCW = $clog2(SETTLE_CYCLES);
  localparam int DCW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_ROW,
    S_WAIT,
    S_NEXT
  } state_e;

  state_e          state_q, state_d;
  logic [CBW-1:0]  col_q, col_d;
  logic [RBW-1:0]  row_q, row_d;
  logic [SCW-1:0]  set_q, set_d;
  logic            evt_valid_q, evt_valid_d;
  logic [KB-1:0]   evt_key_q, evt_key_d;
  logic            evt_pressed_q, evt_pressed_d;
  logic            done_q, done_d;

  logic [ROWS-1:0] sync1_q, sync2_q;
  logic [ROWS-1:0] snap_q;
  logic [NK-1:0]   stable_q;
  logic [DCW-1:0]  cnt_q [NK];

  logic [KB-1:0]   key_w;
  logic            bit_w;
  logic            st_w;
  logic [DCW:0]    inc_w;
  logic            flip_w;
  logic            last_row_w;

  assign key_w      = KB'(32'(col_q) * 32'(ROWS) + 32'(row_q));
  assign bit_w      = snap_q[row_q];
  assign st_w       = stable_q[key_w];
  assign inc_w      = {1'b0, cnt_q[key_w]} + (DCW+1)'(1);
  assign last_row_w = (row_q == RBW'(ROWS - 1));
  assign flip_w     = (state_q == S_ROW) && (bit_w != st_w) &&
                      (inc_w == (DCW+1)'(DEBOUNCE_SCANS));

  // Two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= row_n;
      sync2_q <= sync1_q;
    end
  end

  // Capture pressed rows (active-high) once the column has settled
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
    end else if (state_q == S_SAMPLE) begin
      snap_q <= ~sync2_q;
    end
  end

  // Per-key debounce: count disagreeing scans, flip on the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      for (int i = 0; i < NK; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (state_q == S_ROW) begin
      if (bit_w == st_w) begin
        cnt_q[key_w] <= '0;
      end else if (flip_w) begin
        stable_q[key_w] <= bit_w;
        cnt_q[key_w]    <= '0;
      end else begin
        cnt_q[key_w] <= inc_w[DCW-1:0];
      end
    end
  end

  // Scan FSM state and event register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      set_q         <= '0;
      evt_valid_q   <= 1'b0;
      evt_key_q     <= '0;
      evt_pressed_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      set_q         <= set_d;
      evt_valid_q   <= evt_valid_d;
      evt_key_q     <= evt_key_d;
      evt_pressed_q <= evt_pressed_d;
      done_q        <= done_d;
    end
  end

  // Scan FSM next state: settle, sample, walk rows, stall on events
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    set_d         = set_q;
    evt_valid_d   = evt_valid_q;
    evt_key_d     = evt_key_q;
    evt_pressed_d = evt_pressed_q;
    done_d        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_SETTLE;
          set_d   = '0;
        end
      end
      S_SETTLE: begin
        if (set_q == SCW'(SETTLE_CYCLES - 1)) begin
          state_d = S_SAMPLE;
        end else begin
          set_d = set_q + SCW'(1);
        end
      end
      S_SAMPLE: begin
        state_d = S_ROW;
        row_d   = '0;
      end
      S_ROW: begin
        if (flip_w) begin
          state_d       = S_WAIT;
          evt_valid_d   = 1'b1;
          evt_key_d     = key_w;
          evt_pressed_d = bit_w;
        end else if (last_row_w) begin
          state_d = S_NEXT;
        end else begin
          row_d = row_q + RBW'(1);
        end
      end
      S_WAIT: begin
        if (evt_ready) begin
          evt_valid_d = 1'b0;
          if (last_row_w) begin
            state_d = S_NEXT;
          end else begin
            state_d = S_ROW;
            row_d   = row_q + RBW'(1);
          end
        end
      end
      S_NEXT: begin
        if (col_q == CBW'(COLS - 1)) begin
          col_d  = '0;
          done_d = 1'b1;
        end else begin
          col_d = col_q + CBW'(1);
        end
        set_d   = '0;
        state_d = en ? S_SETTLE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign col_n       = (state_q == S_IDLE) ? '1 : ~(COLS'(1) << col_q);
  assign evt_valid   = evt_valid_q;
  assign evt_key     = evt_key_q;
  assign evt_pressed = evt_pressed_q;
  assign scan_done   = done_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: drives a virtual 8x8 switch matrix and
// checks events against a per-pass debounce reference model.
module tb_key_matrix_scanner;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] col_n;
  logic [7:0] row_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [5:0] evt_key;
  logic       evt_pressed;
  logic       scan_done;

  logic       en1;
  logic [7:0] col1_n;
  logic [7:0] row1_n;
  logic       evt1_valid;
  logic       ready1;
  logic [5:0] evt1_key;
  logic       evt1_pressed;
  logic       scan1_done;

  logic [63:0] press;
  logic [63:0] press1;

  int n_chk;
  int n_fail;

  bit stable_m [64];
  int cnt_m [64];
  logic [6:0] exp_q [$];
  logic [6:0] obs_q [$];
  logic [6:0] obs1_q [$];

  key_matrix_scanner dut (
    .clk(clk), .rst(rst), .en(en),
    .col_n(col_n), .row_n(row_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_key(evt_key), .evt_pressed(evt_pressed),
    .scan_done(scan_done)
  );

  key_matrix_scanner #(.DEBOUNCE_SCANS(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1),
    .col_n(col1_n), .row_n(row1_n),
    .evt_valid(evt1_valid), .evt_ready(ready1),
    .evt_key(evt1_key), .evt_pressed(evt1_pressed),
    .scan_done(scan1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Switch matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row_n  = '1;
    row1_n = '1;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        if (!col_n[c] && press[c*8+r]) row_n[r] = 1'b0;
        if (!col1_n[c] && press1[c*8+r]) row1_n[r] = 1'b0;
      end
    end
  end

  // Record every transfer that will happen at the coming edge
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready)
      obs_q.push_back({evt_pressed, evt_key});
    if (!rst && evt1_valid && ready1)
      obs1_q.push_back({evt1_pressed, evt1_key});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full matrix pass as the debounce rules see it
  function automatic void model_pass(input logic [63:0] p);
    for (int k = 0; k < 64; k++) begin
      if (p[k] == stable_m[k]) begin
        cnt_m[k] = 0;
      end else begin
        cnt_m[k]++;
        if (cnt_m[k] == 4) begin
          stable_m[k] = p[k];
          cnt_m[k] = 0;
          exp_q.push_back({p[k], 6'(k)});
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 64; k++) begin
      stable_m[k] = 1'b0;
      cnt_m[k] = 0;
    end
    exp_q.delete();
  endfunction

  // Drive one pass from its start to scan_done with a fixed key set
  task automatic run_pass(input logic [63:0] p, input bit rnd);
    int n;
    press = p;
    model_pass(p);
    n = 0;
    do begin
      tick();
      evt_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end while (!scan_done && n < 4000);
    evt_ready = 1'b1;
    n_chk++;
    if (scan_done !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_timeout: scan_done=%b after %0d cycles, required 1", scan_done, n);
    end
  endtask

  task automatic realign();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!scan_done && n < 600);
    n_chk++;
    if (scan_done !== 1'b1) begin
      n_fail++;
      $display("FAIL realign_timeout: scan_done=%b, required 1", scan_done);
    end
  endtask

  task automatic test_reset();
    int t;
    rst = 1'b1; en = 1'b0; en1 = 1'b0; evt_ready = 1'b1; ready1 = 1'b1;
    press = '0; press1 = '0;
    model_reset();
    repeat (3) tick();
    n_chk++;
    if (col_n !== 8'hFF || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: col_n=%h valid=%b, required ff/0", col_n, evt_valid);
    end
    n_chk++;
    if (evt_key !== 6'd0 || evt_pressed !== 1'b0 || scan_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_evt: key=%0d pr=%b done=%b, required 0/0/0", evt_key, evt_pressed, scan_done);
    end
    rst = 1'b0; en = 1'b1;
    tick();
    n_chk++;
    if (col_n !== 8'hFE) begin
      n_fail++;
      $display("FAIL start_col0: col_n=%h, required fe", col_n);
    end
    repeat (26) tick();
    n_chk++;
    if (col_n !== 8'hFD) begin
      n_fail++;
      $display("FAIL start_col1: col_n=%h, required fd", col_n);
    end
    t = 27;
    while (!scan_done && t < 400) begin
      tick();
      t++;
    end
    n_chk++;
    if (t !== 209 || scan_done !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_done_time: cycle=%0d done=%b, required 209/1", t, scan_done);
    end
    n_chk++;
    if (col_n !== 8'hFE || obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL wrap: col_n=%h events=%0d, required fe/0", col_n, obs_q.size());
    end
  endtask

  task automatic test_press();
    logic [63:0] p;
    p = 64'd1 << 26;
    repeat (3) run_pass(p, 1'b0);
    n_chk++;
    if (obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL press_early: events=%0d, required 0", obs_q.size());
    end
    run_pass(p, 1'b0);
    n_chk++;
    if (obs_q.size() !== 1 || obs_q[0] !== 7'h5A) begin
      n_fail++;
      $display("FAIL press_evt: n=%0d first=%h, required 1/5a", obs_q.size(), obs_q.size() ? obs_q[0] : 7'h0);
    end
    repeat (3) run_pass('0, 1'b0);
    n_chk++;
    if (obs_q.size() !== 1) begin
      n_fail++;
      $display("FAIL release_early: events=%0d, required 1", obs_q.size());
    end
    run_pass('0, 1'b0);
    n_chk++;
    if (obs_q.size() !== 2 || obs_q[1] !== 7'h1A) begin
      n_fail++;
      $display("FAIL release_evt: n=%0d, required 2 ending 1a", obs_q.size());
    end
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL press_model_cnt: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL press_model[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bounce();
    logic [63:0] p;
    int n;
    p = 64'd1 << 26;
    repeat (3) run_pass(p, 1'b0);
    run_pass('0, 1'b0);
    repeat (3) run_pass(p, 1'b0);
    run_pass('0, 1'b0);
    n_chk++;
    if (obs_q.size() !== 0 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL bounce: events=%0d model=%0d, required 0", obs_q.size(), exp_q.size());
    end
    obs_q.delete(); exp_q.delete();
    press1 = p;
    en1 = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!scan1_done && n < 600);
      press1 = '0;
    end
    en1 = 1'b0;
    n_chk++;
    if (obs1_q.size() !== 2) begin
      n_fail++;
      $display("FAIL db1_count: events=%0d, required 2", obs1_q.size());
    end else begin
      n_chk++;
      if (obs1_q[0] !== 7'h5A || obs1_q[1] !== 7'h1A) begin
        n_fail++;
        $display("FAIL db1_order: got %h %h, required 5a 1a", obs1_q[0], obs1_q[1]);
      end
    end
    realign();
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [63:0] p;
    int n;
    p = 64'd1 << 13;
    repeat (3) run_pass(p, 1'b0);
    press = p;
    model_pass(p);
    evt_ready = 1'b0;
    n = 0;
    while (!evt_valid && n < 400) begin
      tick();
      n++;
    end
    n_chk++;
    if (evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_no_event: valid=%b, required 1", evt_valid);
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      n_chk++;
      if (evt_valid !== 1'b1 || col_n !== 8'hFD || evt_key !== 6'd13 || evt_pressed !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold@%0d: v=%b col=%h key=%0d pr=%b, required 1/fd/13/1", i, evt_valid, col_n, evt_key, evt_pressed);
      end
    end
    n_chk++;
    if (obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL bp_early_xfer: events=%0d, required 0", obs_q.size());
    end
    evt_ready = 1'b1;
    tick();
    n_chk++;
    if (evt_valid !== 1'b0 || obs_q.size() !== 1) begin
      n_fail++;
      $display("FAIL bp_xfer: valid=%b events=%0d, required 0/1", evt_valid, obs_q.size());
    end
    n = 0;
    while (!scan_done && n < 400) begin
      tick();
      n++;
    end
    repeat (4) run_pass('0, 1'b0);
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL bp_model_cnt: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_model[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_simultaneous();
    logic [63:0] p;
    p = (64'd1 << 0) | (64'd1 << 9) | (64'd1 << 63);
    repeat (4) run_pass(p, 1'b0);
    n_chk++;
    if (obs_q.size() !== 3) begin
      n_fail++;
      $display("FAIL simul_count: events=%0d, required 3", obs_q.size());
    end else begin
      n_chk++;
      if (obs_q[0] !== 7'h40 || obs_q[1] !== 7'h49 || obs_q[2] !== 7'h7F) begin
        n_fail++;
        $display("FAIL simul_order: got %h %h %h, required 40 49 7f", obs_q[0], obs_q[1], obs_q[2]);
      end
    end
    repeat (4) run_pass('0, 1'b0);
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL simul_model_cnt: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL simul_model[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_enable();
    logic [7:0] prev;
    int n;
    n = 0;
    while (col_n !== 8'hDF && n < 400) begin
      tick();
      n++;
    end
    repeat (5) tick();
    en = 1'b0;
    prev = col_n;
    n = 0;
    while (col_n !== 8'hFF && n < 100) begin
      prev = col_n;
      tick();
      n++;
    end
    n_chk++;
    if (col_n !== 8'hFF || prev !== 8'hDF) begin
      n_fail++;
      $display("FAIL en_drop: col_n=%h last=%h, required ff after df", col_n, prev);
    end
    repeat (10) tick();
    n_chk++;
    if (col_n !== 8'hFF) begin
      n_fail++;
      $display("FAIL en_idle: col_n=%h, required ff", col_n);
    end
    en = 1'b1;
    tick();
    n_chk++;
    if (col_n !== 8'hBF) begin
      n_fail++;
      $display("FAIL en_resume: col_n=%h, required bf", col_n);
    end
    realign();
  endtask

  task automatic test_reset_wait();
    logic [63:0] p;
    int n;
    p = 64'd1 << 9;
    repeat (3) run_pass(p, 1'b0);
    press = p;
    evt_ready = 1'b0;
    n = 0;
    while (!evt_valid && n < 400) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if (evt_valid !== 1'b0 || col_n !== 8'hFF || obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rst_wait: v=%b col=%h events=%0d, required 0/ff/0", evt_valid, col_n, obs_q.size());
    end
    model_reset();
    obs_q.delete();
    rst = 1'b0;
    evt_ready = 1'b1;
    repeat (3) run_pass(p, 1'b0);
    n_chk++;
    if (obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rst_redeb_early: events=%0d, required 0", obs_q.size());
    end
    run_pass(p, 1'b0);
    n_chk++;
    if (obs_q.size() !== 1 || obs_q[0] !== 7'h49) begin
      n_fail++;
      $display("FAIL rst_redeb: n=%0d, required one event 49", obs_q.size());
    end
    repeat (4) run_pass('0, 1'b0);
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL rst_model_cnt: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rst_model[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [63:0] p;
    logic [63:0] m;
    p = '0;
    for (int pass = 0; pass < 24; pass++) begin
      m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      p = p ^ m;
      run_pass(p, 1'b1);
    end
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_cnt: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_evt[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_press();
    test_bounce();
    test_backpressure();
    test_simultaneous();
    test_enable();
    test_reset_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_matrix_scanner.md
# key_matrix_scanner

Drives the column lines of the keyboard switch matrix and reads back the row lines. It debounces every key independently and emits one press or release event per debounced state change over a valid/ready handshake. It is the reading end of the matrix interface: column strobing is paced by internal settle and row counters, and the event stream feeds the keyboard report logic downstream.

## Interface
- ROWS, 8: number of row inputs.
- COLS, 8: number of column outputs.
- SETTLE_CYCLES, 16: cycles a column is driven before its rows are sampled; must be ≥ 3.
- DEBOUNCE_SCANS, 4: consecutive scans a key must differ from its stable state before it flips; must be ≥ 1.
- KB (localparam): $clog2(ROWS*COLS).

Ports:
- clk  in  1: single clock; all logic on posedge clk.
- rst  in  1: reset, synchronous, active-high.
- en  in  1: scan enable.
- col_n  out  COLS: one-hot active-low column drive; all-ones when idle.
- row_n  in  ROWS: asynchronous row sense, active-low (0 = pressed); 2-flop synchronized internally.
- evt_valid  out  1: event available.
- evt_ready  in  1: downstream accepts event.
- evt_key  out  KB: key index = col*ROWS + row.
- evt_pressed  out  1: 1 = press, 0 = release.
- scan_done  out  1: one-cycle pulse after column COLS-1 completes.

## Operation
- States:
  - IDLE: col_n all-ones.
  - SETTLE: counter 0..SETTLE_CYCLES-1.
  - SAMPLE: latch synchronized ~row_n into row_snap.
  - ROW: row index r = 0..ROWS-1.
  - WAIT: event pending.
  - NEXT: advance column.
- IDLE → SETTLE when en=1. col_n drives the current column, initially 0, starting that edge.
- SETTLE → SAMPLE after SETTLE_CYCLES cycles. SAMPLE → ROW with r=0.
- ROW, per key k = col*ROWS + r, with stable[k] and cnt[k] (width $clog2(DEBOUNCE_SCANS+1)):
  - If row_snap[r] == stable[k]: cnt[k] ← 0.
  - Else, if cnt[k]+1 == DEBOUNCE_SCANS: stable[k] ← row_snap[r], cnt[k] ← 0, evt_valid ← 1, evt_key ← k, evt_pressed ← row_snap[r]; go to WAIT.
  - Else: cnt[k] ← cnt[k]+1.
  - If no event: r==ROWS-1 → NEXT, else r+1.
- WAIT: hold evt_valid, evt_key and evt_pressed stable. On an edge with evt_ready=1, clear evt_valid and resume ROW at r+1, or NEXT if r==ROWS-1. Scanning stalls and col_n holds while waiting.
- NEXT: column wraps COLS-1 → 0. On wrap, scan_done pulses for one cycle. Then en=1 → SETTLE with the new column; en=0 → IDLE.
- en is sampled only in IDLE and NEXT. Deasserting en mid-column finishes that column, including pending events.
- Debounce state (stable, cnt) is retained across IDLE and cleared only by rst.
- Events per column are emitted in ascending row order; columns are visited in ascending order.

## Timing
- Reset (rst=1 at edge) sets all of the following. rst overrides any state, including WAIT; a pending event is dropped.
  - state IDLE, column 0, col_n all-ones.
  - evt_valid 0, evt_key 0, evt_pressed 0, scan_done 0.
  - all stable 0 (released), all cnt 0, synchronizer flops 1.
- Column period with no events: SETTLE_CYCLES + 1 + ROWS + 1 cycles (default 26).
- Each event adds a minimum of 1 cycle (WAIT with evt_ready already high), plus every cycle evt_ready stays low.
- Sample point: row_n must be stable ≥ 3 cycles before the SAMPLE edge (2 for the synchronizer, 1 for capture).
- Transfer happens at an edge where evt_valid && evt_ready. evt_valid never depends combinationally on evt_ready.
- Press-to-event latency: DEBOUNCE_SCANS full matrix passes, up to one additional pass for phase alignment.

## Test plan
- Reset / start: with rst=1, check col_n=8'hFF and evt_valid=0. Release rst with en=1: col_n=8'hFE one cycle later; 8'hFD 26 cycles after that; scan_done pulses after column 7.
- Press key (row 2, col 3), held: exactly one event, evt_key=26, evt_pressed=1, during the 4th pass. On release, one event, key 26, evt_pressed=0, 4 passes later. No other events.
- Bounce reject: press key 26 for 3 passes then release → no event, cnt[26] returns to 0. With DEBOUNCE_SCANS=1, a single-pass press produces press then release events.
- Backpressure: hold evt_ready=0 for 100 cycles during a pending event. col_n, evt_key and evt_pressed stay constant and evt_valid stays 1. One transfer occurs when evt_ready rises, and scanning resumes the next cycle.
- Simultaneous keys: press keys 0, 9 and 63 in the same pass with evt_ready=1. Events arrive in order 0, 9, 63, each exactly once.
- Enable / reset mid-operation:
  - Drop en mid-column 5: column 5 completes, then col_n=8'hFF. Re-enable: scanning resumes at column 6.
  - Assert rst during WAIT: evt_valid=0 next cycle. A key still held re-debounces and is reported again after 4 passes.
